alu_mul_datapath: RTL and testbench
===================================

# alu_mul_datapath

Accumulator-based arithmetic datapath for the picoMips core. Each cycle it forms an operand from the switches, the sign-extended immediate or register-file data. It then either adds that operand to the accumulator or multiplies the accumulator by a fixed-point immediate, and registers the result in the 8-bit ACC. It sits between the register file/decoder and the write-back path and is built from three small combinational leaf modules: `mulmux`, `mul0mux` and `mult`.

## Interface
Parameters: none (8-bit datapath fixed).
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset; one clock, reset asynchronous and active-high.
- Imm  in  8  sign-extended immediate from instruction.
- RegData  in  8  register-file read data.
- SW  in  8  input switches.
- WE  in  1  ACC write enable.
- SelSW  in  1  1: operand = SW (overrides SelImm).
- SelImm  in  1  1: operand = Imm, 0: operand = RegData.
- UseMul  in  1  1: multiply mode, 0: add/load mode.
- UseACC  in  1  1: ACC participates; 0: ACC replaced by 0.
- ACC  out  8  accumulator register.

## Operation
- Operand: `data = SelSW ? SW : (SelImm ? Imm : RegData)`, built as two cascaded `mulmux` instances.
- Accumulator term: `p1 = UseACC ? ACC : 0` (`mul0mux`).
- Data term: `p2 = UseMul ? 0 : data` (`mul0mux` with enable `~UseMul`).
- `sum = p1 + p2`, 8-bit two's complement, wraps silently with no saturation.
- Multiplier operand:
  - `mb = UseMul ? Imm : 8'sd8`.
  - Implemented as `mult(UseMul, Imm)` giving Imm or 0, with bit 3 ORed with `~UseMul`.
  - Imm is interpreted as signed Q4.3 in multiply mode.
- Next ACC:
  - Compute the signed product `sum × mb`, with both operands sign-extended to 11 bits and the product truncated to 11 bits.
  - ACC takes bits [10:3], i.e. the arithmetic shift right by 3, keeping the low 8 bits.
- Resulting modes:
  - UseMul=0: ACC ← (UseACC ? ACC : 0) + data. This covers load (UseACC=0) and add (UseACC=1).
  - UseMul=1, UseACC=1: ACC ← (ACC × Imm) >>> 3, low 8 bits.
  - UseMul=1, UseACC=0: ACC ← 0.
- WE=0: ACC holds regardless of other inputs.

## Timing
- Reset asserted: ACC = 8'h00 immediately (asynchronous), held while Reset is high.
- Reset deasserts: first update on the next rising edge with WE=1.
- Latency:
  - All operand/select paths are combinational.
  - Result is visible on ACC one clock after the inputs are applied with WE=1.
- Each ACC-dependent operation reads the pre-edge ACC, so back-to-back accumulates chain each cycle with no hazard.
- Reset mid-operation discards the pending result; no partial state exists.
- No handshake and no multi-cycle operation; single-cycle throughput.

## Structure
- Shared package `alu_pkg`: `typedef logic signed [7:0] word_t`; constants `FRAC_BITS = 3` and `UNITY = 8'sd8`.
- Leaf sub-modules, all 8-bit and combinational:
  - `mulmux`: 2:1 mux, Sel=1 selects A.
  - `mul0mux`: pass-or-zero, En=1 passes In.
  - `mult`: signed 8×8 multiply, low 8 bits of the product.
- Top instantiates 2× `mulmux`, 2× `mul0mux`, 1× `mult`, plus the adder, the 11-bit product and the ACC register.

## Test plan
- Reset: with ACC=0x55, assert Reset asynchronously between edges -> ACC=0x00 immediately, and stays 0x00 with WE=1 while Reset is held.
- Load switches: SW=0x25, SelSW=1, UseACC=0, UseMul=0, WE=1 -> ACC=0x25 after one edge; then WE=0 with SW=0x99 -> ACC stays 0x25.
- Add immediate then register, with wrap:
  - ACC=0x25, SelSW=0, SelImm=1, Imm=0x03, UseACC=1 -> 0x28.
  - Then ACC=0x7F, SelImm=0, RegData=0x01 -> 0x80.
  - Then RegData=0x81 -> 0x01.
- Multiply:
  - ACC=0x28, UseMul=1, UseACC=1, Imm=0x04 -> ACC=0x14.
  - Then ACC=0x28, Imm=0xF8 -> ACC=0xD8.
  - Then ACC=0x28, Imm=0x08 -> ACC=0x28 (unity).
- Priority and zeroing:
  - SelSW=1 and SelImm=1 with SW=0x11, Imm=0x22, UseACC=0, UseMul=0 -> ACC=0x11.
  - UseMul=1, UseACC=0 -> ACC=0x00.
- Back-to-back: ACC=0x01, Imm=0x01, SelImm=1, UseACC=1, WE held high for 5 cycles -> ACC=0x02 through 0x06, one per edge.

Source files
------------

// File: rtl/alu_mul_datapath_pkg.sv
// Shared types and fixed-point constants for the picoMips accumulator datapath.
// Q4.3 immediates: UNITY is 1.0, so the add path can reuse the multiplier.
package alu_pkg;

  typedef logic signed [7:0] word_t;

  localparam int    FRAC_BITS = 3;
  localparam word_t UNITY     = 8'sd8;

endpackage

// File: rtl/alu_mul_datapath_if.sv
// Control/data bundle between the decoder/register file and the accumulator datapath.
interface alu_mul_datapath_if;
  import alu_pkg::*;

  word_t imm;
  word_t reg_data;
  word_t sw;
  logic  we;
  logic  sel_sw;
  logic  sel_imm;
  logic  use_mul;
  logic  use_acc;
  word_t acc;

  modport master (
    output imm, reg_data, sw, we, sel_sw, sel_imm, use_mul, use_acc,
    input  acc
  );

  modport slave (
    input  imm, reg_data, sw, we, sel_sw, sel_imm, use_mul, use_acc,
    output acc
  );

endinterface

// File: rtl/alu_mul_datapath_leaves.sv
// Combinational 8-bit leaf cells of the accumulator datapath: 2:1 mux,
// pass-or-zero gate and a signed multiplier keeping the low product byte.
module mulmux
  import alu_pkg::*;
(
  input  logic  sel,
  input  word_t a,
  input  word_t b,
  output word_t y
);
  assign y = sel ? a : b;
endmodule

module mul0mux
  import alu_pkg::*;
(
  input  logic  en,
  input  word_t in,
  output word_t y
);
  assign y = en ? in : '0;
endmodule

module mult
  import alu_pkg::*;
(
  input  word_t a,
  input  word_t b,
  output word_t y
);
  // The low byte of a product is identical for signed and unsigned operands.
  assign y = a * b;
endmodule

// File: rtl/alu_mul_datapath.sv
// Accumulator datapath: add/load an operand into ACC, or scale ACC by a Q4.3
// immediate; both modes share one 11-bit multiply followed by a >>> 3.
module alu_mul_datapath
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  alu_mul_datapath_if.slave    bus
);

  word_t acc_q;
  word_t data_lo;
  word_t data;
  word_t p1;
  word_t p2;
  word_t sum;
  word_t mul_imm;
  word_t mb;
  word_t acc_next;

  logic signed [10:0] sum_ext;
  logic signed [10:0] mb_ext;
  logic signed [10:0] prod;

  mulmux u_mux_imm (.sel(bus.sel_imm), .a(bus.imm), .b(bus.reg_data), .y(data_lo));
  mulmux u_mux_sw  (.sel(bus.sel_sw),  .a(bus.sw),  .b(data_lo),      .y(data));

  mul0mux u_zero_acc  (.en(bus.use_acc),  .in(acc_q), .y(p1));
  mul0mux u_zero_data (.en(~bus.use_mul), .in(data),  .y(p2));

  mult u_mult (.a({7'b0, bus.use_mul}), .b(bus.imm), .y(mul_imm));

  // Outside multiply mode the multiplier sees UNITY (8), so the shift cancels out.
  assign mb  = mul_imm | {4'b0, ~bus.use_mul, 3'b0};
  assign sum = p1 + p2;

  assign sum_ext  = 11'(sum);
  assign mb_ext   = 11'(mb);
  assign prod     = sum_ext * mb_ext;
  assign acc_next = prod[FRAC_BITS +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc_q <= '0;
    else if (bus.we)
      acc_q <= acc_next;
  end

  assign bus.acc = acc_q;

endmodule

// File: tb/tb_alu_mul_datapath.sv
// Directed vector bench for alu_mul_datapath; expected ACC values are hand-computed.
module tb_alu_mul_datapath;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_mul_datapath_if bus ();

  alu_mul_datapath dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        sel_sw;
    logic        sel_imm;
    logic        use_mul;
    logic        use_acc;
    logic [7:0]  imm;
    logic [7:0]  reg_data;
    logic [7:0]  sw;
    logic [7:0]  exp_acc;
  } vec_t;

  vec_t vecs[$];

  // Drive on the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    bus.we       = v.we;
    bus.sel_sw   = v.sel_sw;
    bus.sel_imm  = v.sel_imm;
    bus.use_mul  = v.use_mul;
    bus.use_acc  = v.use_acc;
    bus.imm      = v.imm;
    bus.reg_data = v.reg_data;
    bus.sw       = v.sw;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [7:0] exp_acc);
    checks++;
    if (bus.acc !== exp_acc) begin
      failures++;
      $display("[TB] FAIL %s: acc=0x%02h expected=0x%02h", name, bus.acc, exp_acc);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic sel_sw,
                              input logic sel_imm, input logic use_mul, input logic use_acc,
                              input logic [7:0] imm, input logic [7:0] reg_data,
                              input logic [7:0] sw, input logic [7:0] exp_acc);
    vec_t v;
    v.name = name; v.we = we; v.sel_sw = sel_sw; v.sel_imm = sel_imm;
    v.use_mul = use_mul; v.use_acc = use_acc; v.imm = imm;
    v.reg_data = reg_data; v.sw = sw; v.exp_acc = exp_acc;
    return v;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;

    //                 name           we sw im mu ac  imm    reg    sw     exp
    vecs.push_back(mk("load_sw",      1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h25, 8'h25));
    vecs.push_back(mk("hold_we0",     0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h99, 8'h25));
    vecs.push_back(mk("add_imm",      1, 0, 1, 0, 1, 8'h03, 8'h00, 8'h99, 8'h28));
    vecs.push_back(mk("load_7f",      1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h7F, 8'h7F));
    vecs.push_back(mk("add_reg_wrap", 1, 0, 0, 0, 1, 8'h00, 8'h01, 8'h00, 8'h80));
    vecs.push_back(mk("add_reg_81",   1, 0, 0, 0, 1, 8'h00, 8'h81, 8'h00, 8'h01));
    vecs.push_back(mk("load_28a",     1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h28, 8'h28));
    vecs.push_back(mk("mul_half",     1, 0, 1, 1, 1, 8'h04, 8'h00, 8'h00, 8'h14));
    vecs.push_back(mk("load_28b",     1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h28, 8'h28));
    vecs.push_back(mk("mul_neg1",     1, 0, 1, 1, 1, 8'hF8, 8'h00, 8'h00, 8'hD8));
    vecs.push_back(mk("load_28c",     1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h28, 8'h28));
    vecs.push_back(mk("mul_unity",    1, 0, 1, 1, 1, 8'h08, 8'h00, 8'h00, 8'h28));
    vecs.push_back(mk("sw_priority",  1, 1, 1, 0, 0, 8'h22, 8'h00, 8'h11, 8'h11));
    vecs.push_back(mk("mul_noacc",    1, 0, 1, 1, 0, 8'h22, 8'h00, 8'h11, 8'h00));
    vecs.push_back(mk("load_ff",      1, 1, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF));
    vecs.push_back(mk("mul_neg_acc",  1, 0, 1, 1, 1, 8'h10, 8'h00, 8'h00, 8'hFE));

    bus.we = 1'b0; bus.sel_sw = 1'b0; bus.sel_imm = 1'b0; bus.use_mul = 1'b0;
    bus.use_acc = 1'b0; bus.imm = '0; bus.reg_data = '0; bus.sw = '0;
    rst = 1'b1;
    #3;
    check_output("reset_initial", 8'h00);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i].name, vecs[i].exp_acc);
    end

    // Back-to-back accumulate chains off the pre-edge ACC every cycle.
    apply_stimulus(mk("b2b_load", 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h01));
    check_output("b2b_load", 8'h01);
    @(negedge clk);
    bus.sel_sw = 1'b0; bus.sel_imm = 1'b1; bus.use_acc = 1'b1; bus.imm = 8'h01;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("b2b_step%0d", k), 8'(2 + k));
    end

    // Asynchronous reset between edges, then held across edges with WE=1.
    apply_stimulus(mk("load_55", 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h55, 8'h55));
    check_output("load_55", 8'h55);
    @(negedge clk);
    bus.sw = 8'h77; bus.sel_sw = 1'b1; bus.use_acc = 1'b0; bus.we = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_output("reset_async", 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("reset_held%0d", k), 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("after_reset_load", 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
